// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite slave with six read/write registers, an OKAY-write counter and an ID register.
// Independent write (AW/W/B) and read (AR/R) state machines; all handshake outputs are registered.
module axi_lite_reg_responder #(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 6,
   parameter logic [31:0] C_ID_VALUE         = 32'h1D5E_0001
) (
   input  logic                              S00_AXI_ACLK,
   input  logic                              S00_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S00_AXI_AWADDR,
   input  logic [2:0]                        S00_AXI_AWPROT,
   input  logic                              S00_AXI_AWVALID,
   output logic                              S00_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S00_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S00_AXI_WSTRB,
   input  logic                              S00_AXI_WVALID,
   output logic                              S00_AXI_WREADY,
   output logic [1:0]                        S00_AXI_BRESP,
   output logic                              S00_AXI_BVALID,
   input  logic                              S00_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S00_AXI_ARADDR,
   input  logic [2:0]                        S00_AXI_ARPROT,
   input  logic                              S00_AXI_ARVALID,
   output logic                              S00_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S00_AXI_RDATA,
   output logic [1:0]                        S00_AXI_RRESP,
   output logic                              S00_AXI_RVALID,
   input  logic                              S00_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     REG0_OUT
);

   typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA} rstate_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            res[8*b +: 8] = new_v[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_v[8*b +: 8];
         end
      end
      return res;
   endfunction

   wstate_t     r_wstate, w_wstate_nxt;
   rstate_t     r_rstate, w_rstate_nxt;
   logic [31:0] r_regs [0:5];
   logic [31:0] r_wcnt;
   logic [3:0]  r_awidx;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
   logic [1:0]  r_bresp, r_rresp;
   logic [31:0] r_rdata;

   logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_cmt_ok;
   logic [3:0]  w_cmt_idx, w_cmt_strb;
   logic [31:0] w_cmt_data, w_rd_data;
   logic [1:0]  w_rd_resp;
   logic        w_unused;

   assign w_unused = ^{S00_AXI_AWPROT, S00_AXI_ARPROT, S00_AXI_AWADDR[1:0], S00_AXI_ARADDR[1:0]};

   assign w_aw_hs = S00_AXI_AWVALID & r_awready;
   assign w_w_hs  = S00_AXI_WVALID  & r_wready;
   assign w_ar_hs = S00_AXI_ARVALID & r_arready;

   // Write FSM next state; commit fires on the edge completing the later of AW/W.
   always_comb begin
      w_wstate_nxt = r_wstate;
      w_commit     = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            if (w_aw_hs && w_w_hs) begin
               w_wstate_nxt = W_RESP;
               w_commit     = 1'b1;
            end else if (w_aw_hs) begin
               w_wstate_nxt = W_HAVE_ADDR;
            end else if (w_w_hs) begin
               w_wstate_nxt = W_HAVE_DATA;
            end else begin
               w_wstate_nxt = W_IDLE;
            end
         end
         W_HAVE_ADDR: begin
            if (w_w_hs) begin
               w_wstate_nxt = W_RESP;
               w_commit     = 1'b1;
            end else begin
               w_wstate_nxt = W_HAVE_ADDR;
            end
         end
         W_HAVE_DATA: begin
            if (w_aw_hs) begin
               w_wstate_nxt = W_RESP;
               w_commit     = 1'b1;
            end else begin
               w_wstate_nxt = W_HAVE_DATA;
            end
         end
         W_RESP: begin
            if (S00_AXI_BREADY) begin
               w_wstate_nxt = W_IDLE;
            end else begin
               w_wstate_nxt = W_RESP;
            end
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   // Commit operands come from the captured copy when that half arrived earlier.
   always_comb begin
      w_cmt_idx  = S00_AXI_AWADDR[5:2];
      w_cmt_data = S00_AXI_WDATA;
      w_cmt_strb = S00_AXI_WSTRB;
      if (r_wstate == W_HAVE_ADDR) begin
         w_cmt_idx = r_awidx;
      end else begin
         w_cmt_idx = S00_AXI_AWADDR[5:2];
      end
      if (r_wstate == W_HAVE_DATA) begin
         w_cmt_data = r_wdata;
         w_cmt_strb = r_wstrb;
      end else begin
         w_cmt_data = S00_AXI_WDATA;
         w_cmt_strb = S00_AXI_WSTRB;
      end
      w_cmt_ok = (w_cmt_idx < 4'd6);
   end

   always_ff @(posedge S00_AXI_ACLK or negedge S00_AXI_ARESETN) begin
      if (!S00_AXI_ARESETN) begin
         r_wstate  <= W_IDLE;
         r_awidx   <= 4'd0;
         r_wdata   <= 32'd0;
         r_wstrb   <= 4'd0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_wcnt    <= 32'd0;
         for (int i = 0; i < 6; i++) begin
            r_regs[i] <= 32'd0;
         end
      end else begin
         r_wstate  <= w_wstate_nxt;
         r_awready <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_DATA);
         r_wready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_ADDR);
         r_bvalid  <= (w_wstate_nxt == W_RESP);
         if (w_aw_hs) begin
            r_awidx <= S00_AXI_AWADDR[5:2];
         end
         if (w_w_hs) begin
            r_wdata <= S00_AXI_WDATA;
            r_wstrb <= S00_AXI_WSTRB;
         end
         if (w_commit) begin
            r_bresp <= w_cmt_ok ? RESP_OKAY : RESP_SLVERR;
         end
         if (w_commit && w_cmt_ok) begin
            r_wcnt <= r_wcnt + 32'd1;
         end
         for (int i = 0; i < 6; i++) begin
            if (w_commit && (w_cmt_idx == 4'(i))) begin
               r_regs[i] <= byte_merge(r_regs[i], w_cmt_data, w_cmt_strb);
            end
         end
      end
   end

   // Read decode uses register values before any same-edge write commit.
   always_comb begin
      w_rd_data = 32'd0;
      w_rd_resp = RESP_OKAY;
      case (S00_AXI_ARADDR[5:2])
         4'd0:    w_rd_data = r_regs[0];
         4'd1:    w_rd_data = r_regs[1];
         4'd2:    w_rd_data = r_regs[2];
         4'd3:    w_rd_data = r_regs[3];
         4'd4:    w_rd_data = r_regs[4];
         4'd5:    w_rd_data = r_regs[5];
         4'd6:    w_rd_data = r_wcnt;
         4'd7:    w_rd_data = C_ID_VALUE;
         default: begin
            w_rd_data = 32'd0;
            w_rd_resp = RESP_SLVERR;
         end
      endcase
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE: begin
            if (w_ar_hs) begin
               w_rstate_nxt = R_DATA;
            end else begin
               w_rstate_nxt = R_IDLE;
            end
         end
         R_DATA: begin
            if (S00_AXI_RREADY) begin
               w_rstate_nxt = R_IDLE;
            end else begin
               w_rstate_nxt = R_DATA;
            end
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge S00_AXI_ACLK or negedge S00_AXI_ARESETN) begin
      if (!S00_AXI_ARESETN) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= 32'd0;
         r_rresp   <= RESP_OKAY;
      end else begin
         r_rstate  <= w_rstate_nxt;
         r_arready <= (w_rstate_nxt == R_IDLE);
         r_rvalid  <= (w_rstate_nxt == R_DATA);
         if (w_ar_hs) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
         end
      end
   end

   assign S00_AXI_AWREADY = r_awready;
   assign S00_AXI_WREADY  = r_wready;
   assign S00_AXI_BVALID  = r_bvalid;
   assign S00_AXI_BRESP   = r_bresp;
   assign S00_AXI_ARREADY = r_arready;
   assign S00_AXI_RVALID  = r_rvalid;
   assign S00_AXI_RDATA   = r_rdata;
   assign S00_AXI_RRESP   = r_rresp;
   assign REG0_OUT        = r_regs[0];

endmodule
